// File: rtl/uart_pkg.sv
// Shared types and helpers for the streaming UART transmitter.
// The optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 10416;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Words narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic word_parity(input logic [8:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles while enabled and flags
// the wrap cycle (tick) and the cycle before it (pre_tick).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_r;

  // Counter is held at zero whenever no frame is on the line.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear || !enable || (cnt_r == LAST)) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick     = enable && (cnt_r == LAST);
  assign pre_tick = enable && (cnt_r == PRE_LAST);

endmodule

// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter with a one-word holding register for gap-free frames.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int IW = cnt_width(DATA_BITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  tx_state_t            state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] hold_r;
  logic                 hold_full_r;
  logic [IW-1:0]        idx_r;
  logic                 stop_cnt_r;
  logic                 tx_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 tick_s;
  logic                 pre_tick_s;
  logic                 accept_s;
  logic                 last_stop_s;
  logic                 frame_end_s;
  logic                 launch_s;
  logic                 load_s;
  logic [DATA_BITS-1:0] load_word_s;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic parity_r;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (PARITY_ODD != 0);
`endif

  assign accept_s    = i_valid && !hold_full_r;
  assign last_stop_s = (stop_cnt_r == STOP_LAST);
  assign frame_end_s = (state_r == STOP) && tick_s && last_stop_s;
  // A word arriving exactly as the line frees up bypasses the holding register.
  assign launch_s    = accept_s && ((state_r == IDLE) || frame_end_s);
  assign load_s      = launch_s || (frame_end_s && hold_full_r);
  assign load_word_s = hold_full_r ? hold_r : i_data;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .i_reset (i_reset),
    .clear   (load_s),
    .enable  (busy_r),
    .tick    (tick_s),
    .pre_tick(pre_tick_s)
  );

  // Frame sequencer, holding register and registered line outputs.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_r     <= IDLE;
      shift_r     <= {DATA_BITS{1'b0}};
      hold_r      <= {DATA_BITS{1'b0}};
      hold_full_r <= 1'b0;
      idx_r       <= {IW{1'b0}};
      stop_cnt_r  <= 1'b0;
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else begin
      done_r <= (state_r == STOP) && last_stop_s && pre_tick_s;

      if (accept_s && !launch_s) begin
        hold_r      <= i_data;
        hold_full_r <= 1'b1;
      end else if (frame_end_s && hold_full_r) begin
        hold_full_r <= 1'b0;
      end

      if (load_s) begin
        shift_r    <= load_word_s;
`ifdef UART_TX_PARITY_EN
        parity_r   <= word_parity(9'(load_word_s), PAR_ODD);
`endif
        idx_r      <= {IW{1'b0}};
        stop_cnt_r <= 1'b0;
        state_r    <= START;
        tx_r       <= 1'b0;
        busy_r     <= 1'b1;
      end else if (tick_s) begin
        case (state_r)
          START: begin
            state_r <= DATA;
            tx_r    <= shift_r[0];
          end
          DATA: begin
            if (idx_r == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_r <= PARITY;
              tx_r    <= parity_r;
`else
              state_r <= STOP;
              tx_r    <= 1'b1;
`endif
            end else begin
              shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
              tx_r    <= shift_r[1];
              idx_r   <= idx_r + IW'(1);
            end
          end
          PARITY: begin
            state_r <= STOP;
            tx_r    <= 1'b1;
          end
          STOP: begin
            if (last_stop_s) begin
              state_r <= IDLE;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              stop_cnt_r <= 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_ready = !hold_full_r;
  assign o_tx    = tx_r;
  assign o_busy  = busy_r;
  assign o_done  = done_r;

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised UART transmitter that serialises words into asynchronous frames (start, data LSB-first, optional parity, 1 or 2 stop bits) at a fixed clocks-per-bit rate. It takes data over a valid/ready handshake and uses a one-entry holding register, so consecutive frames go out back-to-back with no idle gap. It sits between the byte-producing logic and the board TX pin.

## Interface
- DATA_BITS, 8, data bits per frame; legal 5..9
- CLKS_PER_BIT, 10416, clock cycles per bit; legal ≥ 2
- STOP_BITS, 1, stop bits per frame; legal 1 or 2
- PARITY_ODD, 0, parity sense: 0 even, 1 odd; used only when parity is compiled in
- clk  input  1  system clock; all state changes on rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_data  input  DATA_BITS  word to send; bit 0 goes out first
- i_valid  input  1  i_data is valid
- o_ready  output  1  block can accept a word this cycle
- o_tx  output  1  serial line; idles high
- o_busy  output  1  a frame is on the line
- o_done  output  1  one-cycle pulse in the last cycle of the final stop bit

## Operation
- Handshake: a word is accepted on a rising edge where i_valid && o_ready. o_ready = !hold_full. It does not depend combinationally on i_valid.
- On acceptance, the word is routed as follows:
  - Transmitter in IDLE: the word loads the shift register directly and the FSM enters START at that edge.
  - Transmitter not in IDLE: the word goes to the holding register and hold_full is set.
- FSM states are IDLE, START, DATA, PARITY (only with the macro), STOP.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- The bit counter runs 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide. It wraps to 0 at the end of each bit and the FSM advances on that wrap.
- DATA shifts LSB-first. A $clog2(DATA_BITS)-bit index counts 0..DATA_BITS-1.
- STOP counts STOP_BITS bit periods. At the end of the last one:
  - hold_full set: the held word loads the shift register, hold_full clears, and the FSM goes straight to START, so the new start bit begins the next cycle.
  - hold_full clear: the FSM goes to IDLE.
- Simultaneous accept and hold drain on the same edge: the held word goes to the shift register, the new word goes to the holding register, and hold_full stays set.
- o_tx, o_busy and o_done are registered outputs. o_busy = (state != IDLE).
- i_data is not sampled after acceptance; later changes to i_data have no effect on the frame.
- Reset values: o_tx=1, o_busy=0, o_done=0, o_ready=1. The FSM is in IDLE and both counters and hold_full are 0.
- Reset mid-frame: the frame is aborted and the held word is discarded. o_tx goes high asynchronously with reset assertion.

## Timing
- Latency: with the transmitter in IDLE, o_tx is low in the cycle after the accepting edge.
- Frame length F = (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with parity and 0 without.
- o_done is high for exactly one cycle, the last cycle of the final stop bit.
- Back-to-back: if the next word is accepted any time before the final stop bit ends, the frame-to-frame period is exactly F, with no idle cycles.
- o_ready drops on the edge that fills the holding register. It rises on the edge that drains it.

## Configuration
- UART_TX_PARITY_EN defined: a PARITY state is inserted after DATA, holding XOR of the data bits, XORed with PARITY_ODD.
- UART_TX_PARITY_EN undefined: there is no PARITY state, P = 0, and PARITY_ODD is ignored.

## Structure
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - the localparam function for counter width
  - the default CLKS_PER_BIT
- Sub-module uart_baud_tick generates the per-bit wrap pulse. It has CLKS_PER_BIT as a parameter, a clear input asserted on frame start, and the same clk/i_reset as this block.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless stated otherwise.
- Send 0xA5 from IDLE:
  - o_tx is low for cycles 1-4 after the accepting edge.
  - Data bits are 1,0,1,0,0,1,0,1, each 4 cycles.
  - The stop bit is high for 4 cycles, with o_done on cycle 40.
  - o_busy is high for 40 cycles.
- Present 0x01, 0xFF, 0x00 with i_valid held high:
  - The three frames are contiguous, 120 cycles total, with no high gap between a stop bit and the next start bit.
  - o_ready is low while the holding register is full.
- With UART_TX_PARITY_EN defined, PARITY_ODD=0, send 0x07:
  - The parity bit is 1 and the frame is 44 cycles.
  - With PARITY_ODD=1, the parity bit is 0.
- STOP_BITS=2, DATA_BITS=5, send 0x1F: the frame is 32 cycles, with stop high for 8 cycles.
- Assert i_reset mid-DATA with a word in the holding register:
  - o_tx goes to 1 immediately; o_busy=0 and o_ready=1.
  - No further frame is sent after reset release.
- Change i_data after acceptance: the transmitted bits match the value at the accepting edge.
